shift_sequencer: RTL



---
 rtl/shift_seq_pkg.sv | 19 +
 rtl/shift_step.sv | 23 ++
 rtl/shift_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states and
// default datapath sizes.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-step shift/rotate unit: applies exactly one step of the selected op.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] data_out
);

  // Left/right shifts fill with zero; rotate right wraps bit 0 into the MSB.
  always_comb begin
    data_out = data_in;
    case (op)
      OP_SHL:  data_out = {data_in[WIDTH-2:0], 1'b0};
      OP_SHR:  data_out = {1'b0, data_in[WIDTH-1:1]};
      OP_ROR:  data_out = {data_in[0], data_in[WIDTH-1:1]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Two-channel round-robin front end for a single-step shift datapath.
// A granted request is stepped once per cycle for its count, then the result
// is held on a valid/ready output port with its channel tag.
// Optional per-channel completion counters: define SHIFT_SEQ_PERF_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch0_valid,
  output logic             ch0_ready,
  input  logic [WIDTH-1:0] ch0_data,
  input  logic [1:0]       ch0_op,
  input  logic [CNT_W-1:0] ch0_count,
  input  logic             ch1_valid,
  output logic             ch1_ready,
  input  logic [WIDTH-1:0] ch1_data,
  input  logic [1:0]       ch1_op,
  input  logic [CNT_W-1:0] ch1_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ch,
  output logic             busy
`ifdef SHIFT_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_ch0_done,
  output logic [15:0]      perf_ch1_done
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             ch_q, ch_d;
  logic             rr_q, rr_d;
  logic             grant0, grant1;
  logic [WIDTH-1:0] step_out;

`ifdef SHIFT_SEQ_PERF_EN
  logic [15:0] perf0_q, perf0_d;
  logic [15:0] perf1_q, perf1_d;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_in  (work_q),
    .op       (op_q),
    .data_out (step_out)
  );

  // Arbitration, request capture, stepping and output handshake.
  // rr_q names the channel that wins when both request at once.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
`ifdef SHIFT_SEQ_PERF_EN
    perf0_d = perf0_q;
    perf1_d = perf1_q;
`endif
    case (state_q)
      IDLE: begin
        if (ch0_valid && (!ch1_valid || !rr_q)) begin
          grant0 = 1'b1;
        end else if (ch1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          work_d  = ch0_data;
          op_d    = ch0_op;
          rem_d   = ch0_count;
          ch_d    = 1'b0;
          rr_d    = 1'b1;
          state_d = BUSY;
        end else if (grant1) begin
          work_d  = ch1_data;
          op_d    = ch1_op;
          rem_d   = ch1_count;
          ch_d    = 1'b1;
          rr_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          work_d = step_out;
          rem_d  = rem_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SHIFT_SEQ_PERF_EN
          if (ch_q) perf1_d = perf1_q + 16'd1;
          else      perf0_d = perf0_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      ch_q    <= 1'b0;
      rr_q    <= 1'b0;
`ifdef SHIFT_SEQ_PERF_EN
      perf0_q <= '0;
      perf1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
`ifdef SHIFT_SEQ_PERF_EN
      perf0_q <= perf0_d;
      perf1_q <= perf1_d;
`endif
    end
  end

  // Ready is gated by reset so no request appears accepted while held in reset.
  assign ch0_ready = grant0 & rst_n;
  assign ch1_ready = grant1 & rst_n;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? work_q : '0;
  assign out_ch    = (state_q == DONE) & ch_q;

`ifdef SHIFT_SEQ_PERF_EN
  assign perf_ch0_done = perf0_q;
  assign perf_ch1_done = perf1_q;
`endif

endmodule
